regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

- Write-side companion of the 32x32 register file: merges results from the single-cycle ALU path and the variable-latency load path onto the register file's single write port.
- Load results are buffered in a small FIFO. The ALU has priority, but a starvation counter bounds how long a load can wait.
- Registered outputs drive WriteEn/WriteAddr/WriteData directly.
- Combinational pending-write checks tell decode when a source register still has a write in flight.

## Interface
Parameters:
- DEPTH, 2, load FIFO entries (power of 2, >=2)
- MAX_STARVE, 4, consecutive ALU grants allowed while the FIFO is non-empty before the load is forced

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load result present
- ld_ready  out  1  FIFO can accept (high = not full)
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- wb_en  out  1  register file write enable
- wb_addr  out  5  register file write address
- wb_data  out  32  register file write data
- chk_addr1, chk_addr2  in  5  decode source registers
- chk_hit1, chk_hit2  out  1  write to chk_addrN pending (stall decode)

## Operation
**Input handshake**
- ALU transfer: alu_valid && alu_ready. Load transfer: ld_valid && ld_ready.
- A load with ld_rd==0 is accepted (handshake completes) but is not enqueued.

**Arbitration** (evaluated every cycle; the winner is captured into the output register at the edge):
- starve_cnt==MAX_STARVE && FIFO non-empty: grant FIFO head; alu_ready=0.
- Else alu_valid: grant ALU; alu_ready=1.
- Else FIFO non-empty: grant FIFO head (pop).
- Else: idle.
- alu_ready = !(starve_cnt==MAX_STARVE && FIFO non-empty). It does not depend on alu_valid.

**Starvation counter**
- Increments, saturating at MAX_STARVE, when the ALU is granted while the FIFO is non-empty.
- Clears when the FIFO is granted or the FIFO is empty.

**Output register**
- Granted entry with rd!=0: next cycle wb_en=1, wb_addr=rd, wb_data=data.
- Granted ALU entry with rd==0: consumed; wb_en=0.
- Idle: wb_en=0; wb_addr/wb_data hold their last values.

**FIFO**
- ld_ready = !full, computed before any same-cycle pop (no pass-through when full).
- Push and pop in the same cycle are both honoured; count is unchanged.
- Pointers wrap modulo DEPTH.

**Pending check**
- chk_hitN = (chk_addrN!=0) && (any valid FIFO entry has rd==chk_addrN, or wb_en && wb_addr==chk_addrN).
- Same-cycle inbound ALU/load inputs are not included.

**Reset** (asynchronous, also mid-operation):
- FIFO flushed; pointers, count and starve_cnt = 0.
- wb_en=0, wb_addr=0, wb_data=0.
- alu_ready=0 and ld_ready=0 while rstn is low.
- chk_hitN=0.

## Timing
- ALU accept at edge N → wb_en high in cycle N..N+1 (1-cycle latency).
- Load into an empty FIFO with no ALU traffic: enqueued at edge N, popped at edge N+1, wb_en in cycle N+1..N+2 (2-cycle latency).
- Throughput: one register write per cycle.
- Worst-case load wait behind continuous ALU traffic: MAX_STARVE ALU grants, then a forced load grant.
- ld_ready rises the cycle after a pop from a full FIFO.
- chk_hitN is combinational from state and chk_addrN; no input-to-output path from alu_*/ld_*.

## Structure
- Package wb_pkg holds:
  - typedef wb_entry_t {logic [4:0] rd; logic [31:0] data;}
  - REG_AW=5, XLEN=32
- Sub-module wb_fifo (DEPTH, wb_entry_t):
  - outputs full, empty and per-entry valid/rd for the pending compare
  - push/pop ports
- The top level contains the arbiter, starvation counter, output register and pending compare.

## Test plan
- ALU only: alu_valid with rd=5, data=0x5 at edge 1 → wb_en=1, wb_addr=5, wb_data=0x5 in cycle 1..2. A second write with rd=0, data=0xFF → wb_en=0.
- Load only: ld rd=6, data=0x4 enqueued at edge 1 → wb_en=1, wb_addr=6, wb_data=0x4 in cycle 2..3. chk_addr1=6 → chk_hit1=1 in cycles 1..3, 0 afterwards.
- Starvation (MAX_STARVE=4):
  - Stimulus: continuous ALU traffic to rd=1; one load to rd=7.
  - 4 ALU writes occur, then alu_ready=0 for one cycle.
  - wb_addr=7 follows.
  - ALU writes then resume.
- FIFO full: 2 loads pushed while ALU traffic holds priority → ld_ready=0. A third ld_valid is held off. After one pop, ld_ready=1 the next cycle. Data order is preserved.
- Reset mid-operation: FIFO holds 2 entries and wb_en=1, then rstn is asserted → immediately wb_en=0, wb_addr=0, wb_data=0, ready outputs=0, chk_hit=0. After release, no stale writes appear.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back path.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the ALU/load result handshakes, the register-file write port and
// the decode pending-write check.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;

  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  logic [REG_AW-1:0] chk_addr1;
  logic [REG_AW-1:0] chk_addr2;
  logic              chk_hit1;
  logic              chk_hit2;

  // Producer / decode side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  wb_en, wb_addr, wb_data,
    output chk_addr1, chk_addr2,
    input  chk_hit1, chk_hit2
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output wb_en, wb_addr, wb_data,
    input  chk_addr1, chk_addr2,
    output chk_hit1, chk_hit2
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-result FIFO; exposes per-entry valid/rd so the pending-write compare
// can see every buffered destination.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  wb_entry_t mem [DEPTH];
  ptr_t      wr_ptr;
  ptr_t      rd_ptr;
  cnt_t      count;
  logic      push_ok;
  logic      pop_ok;

  assign full    = (count == cnt_t'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; an entry is only observed while its
  // ent_valid bit is set, so flushing the valid bits is enough.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // NOTE: all state updates are non-blocking so every read in this block sees
  // the pre-edge values, which is what makes push+pop in one cycle safe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (pop_ok) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + ptr_t'(1);
      end
      if (push_ok) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + ptr_t'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and buffered load results onto the single register-file write
// port; ALU has priority, bounded by a starvation counter.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef logic [SW-1:0] starve_t;

  localparam starve_t STARVE_MAX = starve_t'(MAX_STARVE);

  wb_entry_t                    head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;

  starve_t           starve_cnt;
  logic              force_ld;
  logic              grant_alu;
  logic              grant_fifo;
  logic              push;

  logic              wb_en_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [XLEN-1:0]   wb_data_q;

  // A forced load grant blocks the ALU regardless of whether it is asking.
  assign force_ld   = (starve_cnt == STARVE_MAX) && !fifo_empty;
  assign grant_alu  = bus.alu_valid && !force_ld;
  assign grant_fifo = !fifo_empty && !grant_alu;

  assign bus.alu_ready = rstn && !force_ld;
  assign bus.ld_ready  = rstn && !fifo_full;

  // Loads to x0 complete the handshake but are dropped here.
  assign push = bus.ld_valid && bus.ld_ready && (bus.ld_rd != '0);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_entry ('{rd: bus.ld_rd, data: bus.ld_data}),
    .pop        (grant_fifo),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_fifo) begin
        wb_en_q   <= 1'b1;
        wb_addr_q <= head.rd;
        wb_data_q <= head.data;
      end else if (grant_alu && (bus.alu_rd != '0)) begin
        wb_en_q   <= 1'b1;
        wb_addr_q <= bus.alu_rd;
        wb_data_q <= bus.alu_data;
      end else begin
        wb_en_q   <= 1'b0;
      end

      if (fifo_empty || grant_fifo) begin
        starve_cnt <= '0;
      end else if (grant_alu && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + starve_t'(1);
      end
    end
  end

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

  // Pending only looks at committed state: buffered loads and the write
  // already sitting in the output register.
  function automatic logic pending(input logic [REG_AW-1:0] a);
    logic hit;
    hit = wb_en_q && (wb_addr_q == a);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == a)) hit = 1'b1;
    end
    return (a != '0) && hit;
  endfunction

  // NOTE: each output is fully assigned on every pass, so no latch can form.
  always_comb begin
    bus.chk_hit1 = pending(bus.chk_addr1);
    bus.chk_hit2 = pending(bus.chk_addr2);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of regfile_wb_arbiter against a queue-based
// model of the write-back rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int MAX_STARVE = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rstn;

  int tests = 0;
  int fails = 0;

  // Model state: the load buffer as a queue, the wait count, the write port.
  ent_t        q[$];
  int          starve;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH      (DEPTH),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == a) return 1'b1;
    return m_en && (m_addr == a);
  endfunction

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, advance
  // the model at the edge, then check the write port just after the edge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic [4:0] c1, input logic [4:0] c2);
    logic forced;
    logic ld_acc;
    ent_t e;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldat;
    bus.chk_addr1 = c1;
    bus.chk_addr2 = c2;
    @(negedge clk);
    forced = (starve == MAX_STARVE) && (q.size() != 0);
    check("alu_ready", bus.alu_ready, !forced);
    check("ld_ready",  bus.ld_ready,  q.size() < DEPTH);
    check("chk_hit1",  bus.chk_hit1,  m_hit(c1));
    check("chk_hit2",  bus.chk_hit2,  m_hit(c2));

    ld_acc = lv && (q.size() < DEPTH);
    if ((q.size() != 0) && (forced || !av)) begin
      e      = q.pop_front();
      m_en   = 1'b1;
      m_addr = e.rd;
      m_data = e.data;
      starve = 0;
    end else if (av) begin
      if (ard != 5'd0) begin
        m_en   = 1'b1;
        m_addr = ard;
        m_data = adat;
      end else begin
        m_en = 1'b0;
      end
      if (q.size() == 0)              starve = 0;
      else if (starve < MAX_STARVE)   starve = starve + 1;
    end else begin
      m_en   = 1'b0;
      starve = 0;
    end
    if (ld_acc && (lrd != 5'd0)) q.push_back('{rd: lrd, data: ldat});

    @(posedge clk);
    #1;
    check("wb_en",   bus.wb_en,   m_en);
    check("wb_addr", bus.wb_addr, m_addr);
    check("wb_data", bus.wb_data, m_data);
  endtask

  task automatic idle(input logic [4:0] c1);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, c1, 5'd0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.chk_addr1 = '0;   bus.chk_addr2 = '0;
    model_reset();
    #3;
    check("rst_wb_en",     bus.wb_en,     1'b0);
    check("rst_wb_addr",   bus.wb_addr,   5'd0);
    check("rst_wb_data",   bus.wb_data,   32'd0);
    check("rst_alu_ready", bus.alu_ready, 1'b0);
    check("rst_ld_ready",  bus.ld_ready,  1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // ALU only: rd=5 writes, rd=0 is swallowed.
    cycle(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("alu_wb_en",   bus.wb_en,   1'b1);
    check("alu_wb_addr", bus.wb_addr, 5'd5);
    check("alu_wb_data", bus.wb_data, 32'h5);
    cycle(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("alu_x0_wb_en", bus.wb_en, 1'b0);
    idle(5'd0);

    // Load only: two-cycle latency, pending visible until the write retires.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h4, 5'd6, 5'd0);
    check("ld_wb_en_early", bus.wb_en,    1'b0);
    check("ld_hit_fifo",    bus.chk_hit1, 1'b1);
    idle(5'd6);
    check("ld_wb_en",   bus.wb_en,   1'b1);
    check("ld_wb_addr", bus.wb_addr, 5'd6);
    check("ld_wb_data", bus.wb_data, 32'h4);
    idle(5'd6);
    check("ld_hit_clear", bus.chk_hit1, 1'b0);
    idle(5'd6);

    // Starvation: four ALU grants, one forced load, then ALU resumes.
    cycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77, 5'd7, 5'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd1, 32'h101 + i, 1'b0, 5'd0, 32'd0, 5'd7, 5'd1);
    check("starve_alu_blocked", bus.alu_ready, 1'b0);
    cycle(1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'd0, 5'd7, 5'd1);
    check("starve_forced_addr", bus.wb_addr, 5'd7);
    check("starve_forced_data", bus.wb_data, 32'h77);
    cycle(1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'd0, 5'd7, 5'd1);
    check("starve_alu_resume", bus.wb_addr, 5'd1);
    idle(5'd0);

    // FIFO full: two loads fill it, a third waits until one pop has occurred.
    cycle(1'b1, 5'd2, 32'h200, 1'b1, 5'd8, 32'hA, 5'd8, 5'd9);
    cycle(1'b1, 5'd2, 32'h201, 1'b1, 5'd9, 32'hB, 5'd8, 5'd9);
    check("full_ld_ready_low", bus.ld_ready, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd2, 32'h202 + i, 1'b1, 5'd10, 32'hC, 5'd8, 5'd10);
    check("full_pop_first", bus.wb_addr, 5'd8);
    check("full_ld_ready_back", bus.ld_ready, 1'b1);
    cycle(1'b1, 5'd2, 32'h206, 1'b1, 5'd10, 32'hC, 5'd9, 5'd10);
    idle(5'd9);
    check("full_order_2", bus.wb_addr, 5'd9);
    idle(5'd10);
    check("full_order_3", bus.wb_addr, 5'd10);
    check("full_order_3d", bus.wb_data, 32'hC);
    idle(5'd0);

    // Reset mid-operation with two buffered loads and a live write.
    cycle(1'b1, 5'd3, 32'h300, 1'b1, 5'd11, 32'hD, 5'd11, 5'd3);
    cycle(1'b1, 5'd3, 32'h301, 1'b1, 5'd12, 32'hE, 5'd11, 5'd3);
    check("pre_rst_wb_en", bus.wb_en, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_wb_en",     bus.wb_en,     1'b0);
    check("mid_rst_wb_addr",   bus.wb_addr,   5'd0);
    check("mid_rst_wb_data",   bus.wb_data,   32'd0);
    check("mid_rst_alu_ready", bus.alu_ready, 1'b0);
    check("mid_rst_ld_ready",  bus.ld_ready,  1'b0);
    check("mid_rst_hit1",      bus.chk_hit1,  1'b0);
    check("mid_rst_hit2",      bus.chk_hit2,  1'b0);
    model_reset();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle(5'd11);

    // Random traffic with a narrow register range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
